byte_lane_packer: RTL and testbench

//  Write-side initiator for the 16-bit byte-enabled register: packs an 8-bit

---
 rtl/byte_lane_pkg.sv | 33 +++
 rtl/byte_lane_packer_flush_timer.sv | 31 +++
 rtl/byte_lane_packer.sv | 95 +++++++++
 tb/tb_byte_lane_packer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_lane_pkg.sv
// Shared byte-lane types for the 16-bit byteena write path: strobe codes,
// packer state encoding and the write payload carried by the output slot.
package byte_lane_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned BE_W   = 2;

  localparam logic [BE_W-1:0] BE_NONE = 2'b00;
  localparam logic [BE_W-1:0] BE_LO   = 2'b01;
  localparam logic [BE_W-1:0] BE_HI   = 2'b10;
  localparam logic [BE_W-1:0] BE_BOTH = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [BE_W-1:0]   be;
  } wr_word_t;

  function automatic wr_word_t make_word(input logic [BYTE_W-1:0] hi,
                                         input logic [BYTE_W-1:0] lo,
                                         input logic [BE_W-1:0]   be);
    wr_word_t w;
    w.data = {hi, lo};
    w.be   = be;
    return w;
  endfunction

endpackage

// File: rtl/byte_lane_packer_flush_timer.sv
// Saturating idle counter; expires after TIMEOUT enabled cycles since clear.
// TIMEOUT=0 keeps the counter parked at zero and never expires.
module flush_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired_c
);

  localparam int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic ENABLED = (TIMEOUT != 0);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (ENABLED && i_enable && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired_c = ENABLED && (r_count == CNT_MAX);

endmodule

// File: rtl/byte_lane_packer.sv
// Packs an 8-bit valid/ready byte stream into 16-bit byteena writes,
// flushing a lone low byte on packet end or after an idle timeout.
module byte_lane_packer
  import byte_lane_pkg::*;
#(
  parameter int unsigned FLUSH_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BYTE_W-1:0]   in_byte,
  input  logic                in_last,
  input  logic                in_odd,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [WORD_W-1:0]   wr_data,
  output logic [BE_W-1:0]     wr_byteena
);

  state_t              r_state;
  logic [BYTE_W-1:0]   r_hold;
  wr_word_t            r_slot;
  logic                r_wr_valid;

  logic w_slot_free;
  logic w_accept;
  logic w_expired;
  logic w_flush;
  logic w_timer_clear;
  logic w_timer_en;

  // The slot can take a new word when empty or when it drains this cycle.
  assign w_slot_free   = !r_wr_valid || wr_ready;
  assign w_accept      = in_valid && w_slot_free;
  assign w_flush       = (r_state == ST_HALF) && !w_accept && w_expired && w_slot_free;
  assign w_timer_clear = (r_state == ST_EMPTY) || w_accept || w_flush;
  assign w_timer_en    = (r_state == ST_HALF) && !w_accept;

  flush_timer #(
    .TIMEOUT (FLUSH_TIMEOUT)
  ) u_flush_timer (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_timer_clear),
    .i_enable    (w_timer_en),
    .o_expired_c (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_hold     <= '0;
      r_slot     <= '0;
      r_wr_valid <= 1'b0;
    end else begin
      if (r_wr_valid && wr_ready) begin
        r_wr_valid <= 1'b0;
      end
      // A new word loaded below overrides the drain above (no bubble).
      if (w_accept) begin
        case (r_state)
          ST_EMPTY: begin
            if (in_odd) begin
              r_slot     <= make_word(in_byte, 8'h00, BE_HI);
              r_wr_valid <= 1'b1;
            end else if (in_last) begin
              r_slot     <= make_word(8'h00, in_byte, BE_LO);
              r_wr_valid <= 1'b1;
            end else begin
              r_hold  <= in_byte;
              r_state <= ST_HALF;
            end
          end
          ST_HALF: begin
            r_slot     <= make_word(in_byte, r_hold, BE_BOTH);
            r_wr_valid <= 1'b1;
            r_state    <= ST_EMPTY;
          end
          default: r_state <= ST_EMPTY;
        endcase
      end else if (w_flush) begin
        r_slot     <= make_word(8'h00, r_hold, BE_LO);
        r_wr_valid <= 1'b1;
        r_state    <= ST_EMPTY;
      end
    end
  end

  assign in_ready   = w_slot_free;
  assign wr_valid   = r_wr_valid;
  assign wr_data    = r_slot.data;
  assign wr_byteena = r_slot.be;

endmodule

// File: tb/tb_byte_lane_packer.sv
// Self-checking bench for byte_lane_packer: directed vector table, corner
// sequences and a random stream against a cycle-level reference model.
module tb_byte_lane_packer;

  localparam int unsigned T = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        in_odd;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [1:0]  wr_byteena;

  byte_lane_packer #(.FLUSH_TIMEOUT(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .in_last    (in_last),
    .in_odd     (in_odd),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_byteena (wr_byteena)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one pending-byte register, one write slot, idle count.
  bit          m_half;
  logic [7:0]  m_hold;
  int unsigned m_idle;
  bit          m_sv;
  logic [15:0] m_sd;
  logic [1:0]  m_sb;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  typedef struct {
    logic [7:0]  b;
    bit          odd;
    bit          last;
    bit          chk;
    logic [15:0] d;
    logic [1:0]  be;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_emit(input logic [15:0] d, input logic [1:0] be);
    m_sv = 1'b1;
    m_sd = d;
    m_sb = be;
  endtask

  // Drive one cycle, check outputs against the model, advance model and clock.
  task automatic cycle(input bit v, input logic [7:0] b, input bit last,
                       input bit odd, input bit rdy, output bit acc);
    bit slot_free;
    in_valid = v; in_byte = b; in_last = last; in_odd = odd; wr_ready = rdy;
    #1;
    slot_free = !m_sv || rdy;
    chk("wr_valid", 32'(wr_valid), 32'(m_sv));
    chk("in_ready", 32'(in_ready), 32'(slot_free));
    if (m_sv) begin
      chk("wr_data", 32'(wr_data), 32'(m_sd));
      chk("wr_byteena", 32'(wr_byteena), 32'(m_sb));
    end
    if (wr_valid) chk("be_nonzero", 32'(wr_byteena != 2'b00), 32'd1);
    acc = v && in_ready;
    if (acc) txq.push_back(b);
    if (wr_valid && rdy) begin
      if (wr_byteena[0]) rxq.push_back(wr_data[7:0]);
      if (wr_byteena[1]) rxq.push_back(wr_data[15:8]);
    end
    if (m_sv && rdy) m_sv = 1'b0;
    if (v && slot_free) begin
      if (m_half) begin
        m_emit({b, m_hold}, 2'b11);
        m_half = 1'b0;
      end else if (odd) begin
        m_emit({b, 8'h00}, 2'b10);
      end else if (last) begin
        m_emit({8'h00, b}, 2'b01);
      end else begin
        m_half = 1'b1;
        m_hold = b;
        m_idle = 0;
      end
    end else if (m_half) begin
      if (T != 0 && m_idle >= T && slot_free) begin
        m_emit({8'h00, m_hold}, 2'b01);
        m_half = 1'b0;
      end else begin
        m_idle++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_be", 32'(wr_byteena), 32'd0);
    m_half = 0; m_hold = '0; m_idle = 0; m_sv = 0; m_sd = '0; m_sb = '0;
    txq.delete();
    rxq.delete();
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);
  endtask

  task automatic compare_streams(input string name);
    int mism = 0;
    chk({name, "_len"}, 32'(rxq.size()), 32'(txq.size()));
    for (int i = 0; i < rxq.size() && i < txq.size(); i++)
      if (rxq[i] !== txq[i]) mism++;
    chk({name, "_bytes"}, 32'(mism), 32'd0);
    txq.delete();
    rxq.delete();
  endtask

  initial begin
    bit a;
    int k;
    int acc_n;
    int cyc;
    logic [7:0] bq[$];

    in_valid = 0; in_byte = '0; in_last = 0; in_odd = 0; wr_ready = 0;
    do_reset();

    // Reset while a low byte is held: it must be dropped.
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, a);
    do_reset();
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, a);
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, a);
    chk("post_rst_data", 32'(wr_data), 32'h3322);
    chk("post_rst_be", 32'(wr_byteena), 32'h3);
    // Reset with a write stuck in the slot.
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, a);
    chk("pend_valid", 32'(wr_valid), 32'd1);
    do_reset();

    vt[0] = '{8'hA1, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00};
    vt[1] = '{8'hB2, 1'b0, 1'b0, 1'b1, 16'hB2A1, 2'b11};
    vt[2] = '{8'hC3, 1'b1, 1'b0, 1'b1, 16'hC300, 2'b10};
    vt[3] = '{8'hD4, 1'b0, 1'b1, 1'b1, 16'h00D4, 2'b01};
    vt[4] = '{8'hE5, 1'b1, 1'b1, 1'b1, 16'hE500, 2'b10};
    vt[5] = '{8'hF6, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00};
    vt[6] = '{8'h07, 1'b1, 1'b1, 1'b1, 16'h07F6, 2'b11};
    vt[7] = '{8'h18, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00};
    vt[8] = '{8'h29, 1'b0, 1'b1, 1'b1, 16'h2918, 2'b11};
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, vt[i].b, vt[i].last, vt[i].odd, 1'b1, a);
      chk("tbl_valid", 32'(wr_valid), 32'(vt[i].chk));
      if (vt[i].chk) begin
        chk("tbl_data", 32'(wr_data), 32'(vt[i].d));
        chk("tbl_be", 32'(wr_byteena), 32'(vt[i].be));
      end
    end

    // Timeout: lone low byte flushes on the 16th idle cycle.
    cycle(1'b1, 8'h5E, 1'b0, 1'b0, 1'b1, a);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a);
      if (wr_valid) begin
        k = i;
        break;
      end
    end
    chk("tmo_cycles", 32'(k), 32'(T + 1));
    chk("tmo_data", 32'(wr_data), 32'h005E);
    chk("tmo_be", 32'(wr_byteena), 32'h1);

    // A byte arriving as the timer expires wins over the flush.
    cycle(1'b1, 8'h5E, 1'b0, 1'b0, 1'b1, a);
    idle(int'(T));
    chk("tmo_race_quiet", 32'(wr_valid), 32'd0);
    cycle(1'b1, 8'h6F, 1'b0, 1'b0, 1'b1, a);
    chk("tmo_race_valid", 32'(wr_valid), 32'd1);
    chk("tmo_race_data", 32'(wr_data), 32'h6F5E);
    chk("tmo_race_be", 32'(wr_byteena), 32'h3);
    idle(4);
    compare_streams("directed");

    // Backpressure across four bytes.
    bq = '{8'h31, 8'h42, 8'h53, 8'h64};
    for (int c = 0; c < 40 && bq.size() > 0; c++) begin
      if (c == 4) begin
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold", 32'(wr_data), 32'h4231);
      end
      cycle(1'b1, bq[0], 1'b0, 1'b0, c >= 6, a);
      if (a) void'(bq.pop_front());
    end
    chk("bp_all_sent", 32'(bq.size()), 32'd0);
    idle(4);
    compare_streams("bp");

    // Random stream.
    acc_n = 0;
    cyc = 0;
    while (acc_n < 10000 && cyc < 60000) begin
      cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 8) == 0,
            ($urandom % 16) == 0, ($urandom % 4) != 0, a);
      if (a) acc_n++;
      cyc++;
    end
    chk("rand_count", 32'(acc_n), 32'd10000);
    idle(40);
    compare_streams("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
